// File: rtl/corrode_frame_ctrl_if.sv
// Control/result bundle between the erosion stream, the frame controller and the overlay stage.
// Only pre_clk and rst stay outside the bundle.
interface corrode_frame_ctrl_if #(
    parameter int CW  = 10,
    parameter int PCW = 19
);
    logic           i_start;
    logic           i_cont;
    logic           i_vsync;
    logic           i_valid;
    logic           i_wb;
    logic           i_box_ready;
    logic           o_busy;
    logic [CW-1:0]  o_cnt_x;
    logic [CW-1:0]  o_cnt_y;
    logic [CW-1:0]  o_x0;
    logic [CW-1:0]  o_x1;
    logic [CW-1:0]  o_y0;
    logic [CW-1:0]  o_y1;
    logic [PCW-1:0] o_pix;
    logic           o_found;
    logic           o_box_valid;
    logic           o_drop;
    logic           o_frame_err;

    modport master (
        output i_start, i_cont, i_vsync, i_valid, i_wb, i_box_ready,
        input  o_busy, o_cnt_x, o_cnt_y, o_x0, o_x1, o_y0, o_y1,
               o_pix, o_found, o_box_valid, o_drop, o_frame_err
    );

    modport slave (
        input  i_start, i_cont, i_vsync, i_valid, i_wb, i_box_ready,
        output o_busy, o_cnt_x, o_cnt_y, o_x0, o_x1, o_y0, o_y1,
               o_pix, o_found, o_box_valid, o_drop, o_frame_err
    );
endinterface

// File: rtl/corrode_frame_ctrl.sv
// Frame controller for the eroded stream: coordinates, white bounding box and count, one result per frame.
// Result valid 2 cycles after the last pixel; held until i_box_ready, later results dropped while held.
module corrode_frame_ctrl #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int CW      = 10,
    parameter int PCW     = 19,
    parameter int MIN_PIX = 16
) (
    input  logic               pre_clk,
    input  logic               rst,
    corrode_frame_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]  X_LAST  = CW'(H_ACT - 1);
    localparam logic [CW-1:0]  Y_LAST  = CW'(V_ACT - 1);
    localparam logic [PCW-1:0] PIX_MAX = '1;
    localparam logic [PCW-1:0] PIX_MIN = PCW'(MIN_PIX);

    logic [1:0]     state;
    logic [CW-1:0]  cnt_x, cnt_y;
    logic [CW-1:0]  acc_x0, acc_x1, acc_y0, acc_y1;
    logic [PCW-1:0] acc_pix;
    logic           acc_any;
    logic [CW-1:0]  res_x0, res_x1, res_y0, res_y1;
    logic [PCW-1:0] res_pix;
    logic           res_found;
    logic           box_valid;
    logic           drop;
    logic           frame_err;

    logic           restart, take, white, first_white, last_pix;
    logic [CW-1:0]  pos_x, pos_y;
    logic [PCW-1:0] pix_base;

    // A vsync inside RUN restarts the frame; a pixel arriving with it is (0,0) of the new frame.
    always_comb begin
        restart     = (state == S_RUN) && bus.i_vsync;
        take        = (state == S_RUN) && bus.i_valid;
        white       = take && bus.i_wb;
        pos_x       = restart ? '0 : cnt_x;
        pos_y       = restart ? '0 : cnt_y;
        pix_base    = restart ? '0 : acc_pix;
        first_white = restart || !acc_any;
        last_pix    = take && (pos_x == X_LAST) && (pos_y == Y_LAST);
    end

    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt_x     <= '0;
            cnt_y     <= '0;
            acc_x0    <= '0;
            acc_x1    <= '0;
            acc_y0    <= '0;
            acc_y1    <= '0;
            acc_pix   <= '0;
            acc_any   <= 1'b0;
            res_x0    <= '0;
            res_x1    <= '0;
            res_y0    <= '0;
            res_y1    <= '0;
            res_pix   <= '0;
            res_found <= 1'b0;
            box_valid <= 1'b0;
            drop      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            drop      <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.i_start) state <= S_ARM;
                end
                S_ARM: begin
                    if (bus.i_vsync) begin
                        state   <= S_RUN;
                        cnt_x   <= '0;
                        cnt_y   <= '0;
                        acc_x0  <= '0;
                        acc_x1  <= '0;
                        acc_y0  <= '0;
                        acc_y1  <= '0;
                        acc_pix <= '0;
                        acc_any <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (restart) begin
                        frame_err <= 1'b1;
                        cnt_x     <= '0;
                        cnt_y     <= '0;
                        acc_x0    <= '0;
                        acc_x1    <= '0;
                        acc_y0    <= '0;
                        acc_y1    <= '0;
                        acc_pix   <= '0;
                        acc_any   <= 1'b0;
                    end
                    if (take) begin
                        if (last_pix) begin
                            cnt_x <= '0;
                            cnt_y <= '0;
                            state <= S_DONE;
                        end else if (pos_x == X_LAST) begin
                            cnt_x <= '0;
                            cnt_y <= pos_y + CW'(1);
                        end else begin
                            cnt_x <= pos_x + CW'(1);
                            cnt_y <= pos_y;
                        end
                    end
                    // Raster order: the first white pixel fixes y0, every later one is the new y1.
                    if (white) begin
                        acc_any <= 1'b1;
                        acc_x0  <= (first_white || pos_x < acc_x0) ? pos_x : acc_x0;
                        acc_x1  <= (first_white || pos_x > acc_x1) ? pos_x : acc_x1;
                        acc_y0  <= first_white ? pos_y : acc_y0;
                        acc_y1  <= pos_y;
                        acc_pix <= (pix_base == PIX_MAX) ? pix_base : pix_base + PCW'(1);
                    end
                end
                default: begin
                    state <= bus.i_cont ? S_ARM : S_IDLE;
                end
            endcase

            // Acceptance in the publishing cycle frees the slot, so the new result replaces the old.
            if (state == S_DONE && (!box_valid || bus.i_box_ready)) begin
                res_x0    <= acc_x0;
                res_x1    <= acc_x1;
                res_y0    <= acc_y0;
                res_y1    <= acc_y1;
                res_pix   <= acc_pix;
                res_found <= (acc_pix >= PIX_MIN);
                box_valid <= 1'b1;
            end else if (state == S_DONE) begin
                drop <= 1'b1;
            end else if (box_valid && bus.i_box_ready) begin
                box_valid <= 1'b0;
            end
        end
    end

    assign bus.o_busy      = (state != S_IDLE);
    assign bus.o_cnt_x     = cnt_x;
    assign bus.o_cnt_y     = cnt_y;
    assign bus.o_x0        = res_x0;
    assign bus.o_x1        = res_x1;
    assign bus.o_y0        = res_y0;
    assign bus.o_y1        = res_y1;
    assign bus.o_pix       = res_pix;
    assign bus.o_found     = res_found;
    assign bus.o_box_valid = box_valid;
    assign bus.o_drop      = drop;
    assign bus.o_frame_err = frame_err;
endmodule

// File: tb/tb_corrode_frame_ctrl.sv
// Bench for corrode_frame_ctrl on an 8x4 frame: frame-index reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_corrode_frame_ctrl;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int MINP = 2;
    localparam int CW   = 10;
    localparam int PCW  = 19;
    localparam int PMAX = (1 << PCW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    corrode_frame_ctrl_if #(.CW(CW), .PCW(PCW)) ifc ();

    corrode_frame_ctrl #(
        .H_ACT(H), .V_ACT(V), .CW(CW), .PCW(PCW), .MIN_PIX(MINP)
    ) dut (
        .pre_clk(clk),
        .rst    (rst),
        .bus    (ifc.slave)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 publishing; position is a raster index.
    int m_ph = 0, m_idx = 0, m_cnt = 0;
    int m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;
    bit m_any = 0;
    int e_x0 = 0, e_x1 = 0, e_y0 = 0, e_y1 = 0, e_pix = 0;
    bit e_found = 0, e_bv = 0, e_drop = 0, e_ferr = 0;

    task automatic clear_stats();
        m_cnt = 0; m_any = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
    endtask

    always @(posedge clk) begin
        int x, y;
        if (rst) begin
            m_ph = 0; m_idx = 0; clear_stats();
            e_x0 = 0; e_x1 = 0; e_y0 = 0; e_y1 = 0; e_pix = 0;
            e_found = 0; e_bv = 0; e_drop = 0; e_ferr = 0;
        end else begin
            e_drop = 0;
            e_ferr = 0;
            if (m_ph == 3) begin
                if (!e_bv || ifc.i_box_ready) begin
                    e_x0 = m_x0; e_x1 = m_x1; e_y0 = m_y0; e_y1 = m_y1;
                    e_pix = m_cnt; e_found = (m_cnt >= MINP); e_bv = 1;
                end else begin
                    e_drop = 1;
                end
            end else if (e_bv && ifc.i_box_ready) begin
                e_bv = 0;
            end
            case (m_ph)
                0: if (ifc.i_start) m_ph = 1;
                1: if (ifc.i_vsync) begin m_ph = 2; m_idx = 0; clear_stats(); end
                2: begin
                    if (ifc.i_vsync) begin e_ferr = 1; m_idx = 0; clear_stats(); end
                    if (ifc.i_valid) begin
                        x = m_idx % H;
                        y = m_idx / H;
                        if (ifc.i_wb) begin
                            m_x0 = m_any ? ((x < m_x0) ? x : m_x0) : x;
                            m_x1 = m_any ? ((x > m_x1) ? x : m_x1) : x;
                            m_y0 = m_any ? ((y < m_y0) ? y : m_y0) : y;
                            m_y1 = m_any ? ((y > m_y1) ? y : m_y1) : y;
                            m_any = 1;
                            m_cnt = (m_cnt < PMAX) ? m_cnt + 1 : PMAX;
                        end
                        m_idx++;
                        if (m_idx == H * V) begin m_idx = 0; m_ph = 3; end
                    end
                end
                default: m_ph = ifc.i_cont ? 1 : 0;
            endcase
        end
        #1;
        check("busy",      int'(ifc.o_busy),      int'(m_ph != 0));
        check("cnt_x",     int'(ifc.o_cnt_x),     m_idx % H);
        check("cnt_y",     int'(ifc.o_cnt_y),     m_idx / H);
        check("box_valid", int'(ifc.o_box_valid), int'(e_bv));
        check("x0",        int'(ifc.o_x0),        e_x0);
        check("x1",        int'(ifc.o_x1),        e_x1);
        check("y0",        int'(ifc.o_y0),        e_y0);
        check("y1",        int'(ifc.o_y1),        e_y1);
        check("pix",       int'(ifc.o_pix),       e_pix);
        check("found",     int'(ifc.o_found),     int'(e_found));
        check("drop",      int'(ifc.o_drop),      int'(e_drop));
        check("frame_err", int'(ifc.o_frame_err), int'(e_ferr));
    end

    task automatic step(input bit st, input bit vs, input bit v, input bit wb);
        @(negedge clk);
        ifc.i_start = st;
        ifc.i_vsync = vs;
        ifc.i_valid = v;
        ifc.i_wb    = wb;
    endtask

    task automatic frame(input logic [31:0] mask, input bit gaps);
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 1, mask[i]);
            if (gaps) begin
                step(0, 0, 0, 1'($urandom));
                if (i == 7) begin
                    check("wrap_x", int'(ifc.o_cnt_x), 0);
                    check("wrap_y", int'(ifc.o_cnt_y), 1);
                end
            end
        end
    endtask

    task automatic check_box(input string nm, input int x0, input int x1, input int y0,
                             input int y1, input int pix, input int found);
        check({nm, "_bv"},    int'(ifc.o_box_valid), 1);
        check({nm, "_x0"},    int'(ifc.o_x0), x0);
        check({nm, "_x1"},    int'(ifc.o_x1), x1);
        check({nm, "_y0"},    int'(ifc.o_y0), y0);
        check({nm, "_y1"},    int'(ifc.o_y1), y1);
        check({nm, "_pix"},   int'(ifc.o_pix), pix);
        check({nm, "_found"}, int'(ifc.o_found), found);
    endtask

    task automatic accept();
        ifc.i_box_ready = 1;
        step(0, 0, 0, 0);
        ifc.i_box_ready = 0;
        check("accept_bv", int'(ifc.o_box_valid), 0);
    endtask

    initial begin
        ifc.i_start = 0; ifc.i_cont = 0; ifc.i_vsync = 0;
        ifc.i_valid = 0; ifc.i_wb = 0; ifc.i_box_ready = 0;

        @(negedge clk);
        check("rst_busy", int'(ifc.o_busy), 0);
        check("rst_bv",   int'(ifc.o_box_valid), 0);
        check("rst_pix",  int'(ifc.o_pix), 0);
        rst = 0;

        // Basic box: white at (2,1), (5,1), (3,2)
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        frame(32'h0008_2400, 0);
        step(0, 0, 0, 0);
        check("basic_lat1_bv",   int'(ifc.o_box_valid), 0);
        check("basic_lat1_busy", int'(ifc.o_busy), 1);
        step(0, 0, 0, 0);
        check("basic_idle", int'(ifc.o_busy), 0);
        check_box("basic", 2, 5, 1, 2, 3, 1);
        accept();

        // Empty frame, then a single white pixel at (7,3)
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        frame(32'h0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_box("empty", 0, 0, 0, 0, 0, 0);
        accept();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        frame(32'h8000_0000, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_box("single", 7, 7, 3, 3, 1, 0);
        accept();

        // Back-pressure across two frames in continuous mode
        ifc.i_cont = 1;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        frame(32'h0000_0110, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_box("bp_first", 0, 4, 0, 1, 2, 1);
        check("bp_armed", int'(ifc.o_busy), 1);
        ifc.i_cont = 0;
        step(0, 1, 0, 0);
        frame(32'hF000_0000, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("bp_drop", int'(ifc.o_drop), 1);
        check_box("bp_held", 0, 4, 0, 1, 2, 1);
        step(0, 0, 0, 0);
        check("bp_drop_once", int'(ifc.o_drop), 0);
        accept();

        // Mid-frame vsync after 10 pixels; the stale white at (3,0) must not survive
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, i == 3);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("ferr_pulse", int'(ifc.o_frame_err), 1);
        check("ferr_cx",    int'(ifc.o_cnt_x), 0);
        check("ferr_cy",    int'(ifc.o_cnt_y), 0);
        step(0, 0, 0, 0);
        check("ferr_once",  int'(ifc.o_frame_err), 0);
        frame(32'h0000_0020, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_box("ferr_frame", 5, 5, 0, 0, 1, 0);
        accept();

        // Valid gaps with line wrap
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        frame(32'h0000_0081, 1);
        step(0, 0, 0, 0);
        check_box("gaps", 0, 7, 0, 0, 2, 1);

        // Reset mid-frame with a result pending
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        rst = 1;
        #1;
        check("mrst_busy",  int'(ifc.o_busy), 0);
        check("mrst_bv",    int'(ifc.o_box_valid), 0);
        check("mrst_cx",    int'(ifc.o_cnt_x), 0);
        check("mrst_cy",    int'(ifc.o_cnt_y), 0);
        check("mrst_x1",    int'(ifc.o_x1), 0);
        check("mrst_pix",   int'(ifc.o_pix), 0);
        check("mrst_found", int'(ifc.o_found), 0);
        step(0, 0, 0, 0);
        rst = 0;
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("mrst_noarm_busy", int'(ifc.o_busy), 0);
        check("mrst_noarm_cx",   int'(ifc.o_cnt_x), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
            ifc.i_box_ready = ($urandom_range(0, 3) == 0);
            ifc.i_cont      = $urandom_range(0, 1) == 1;
            rst             = ($urandom_range(0, 499) == 0);
        end
        step(0, 0, 0, 0);
        rst = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
